// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing: divides clk to the pixel rate and produces counters, syncs and strobes.
// All outputs are registered, with decodes aligned to the counters; free-running, no back-pressure.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixel_tick,
  output logic [9:0] Hcount,
  output logic [9:0] Vcount,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // Decode thresholds kept at 32 bits so the sums are never truncated.
  localparam logic [31:0] H_VIS    = 32'(H_DISPLAY);
  localparam logic [31:0] HS_BEG   = 32'(H_DISPLAY + H_FRONT);
  localparam logic [31:0] HS_END   = 32'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [31:0] V_VIS    = 32'(V_DISPLAY);
  localparam logic [31:0] VS_BEG   = 32'(V_DISPLAY + V_FRONT);
  localparam logic [31:0] VS_END   = 32'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic             tick_q, tick_d;
  logic             fs_q, fs_d;
  logic             von_q, von_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             adv;
  logic [31:0]      h_w, v_w;

  always_comb begin
    adv   = (div_q == DIV_LAST);
    div_d = adv ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (adv) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    tick_d = adv;
    fs_d   = adv && (h_q == H_LAST) && (v_q == V_LAST);
    // Decode the next position so the registered flags line up with the counters.
    h_w    = 32'(h_d);
    v_w    = 32'(v_d);
    von_d  = (h_w < H_VIS) && (v_w < V_VIS);
    hs_d   = !((h_w >= HS_BEG) && (h_w < HS_END));
    vs_d   = !((v_w >= VS_BEG) && (v_w < VS_END));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      tick_q <= 1'b0;
      fs_q   <= 1'b0;
      von_q  <= 1'b1;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      tick_q <= tick_d;
      fs_q   <= fs_d;
      von_q  <= von_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign pixel_tick  = tick_q;
  assign Hcount      = h_q;
  assign Vcount      = v_q;
  assign video_on    = von_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: several geometries/dividers compared every clk against a position-from-time model.
// Reset release and a mid-run asynchronous reset are placed at random times.
module tb_vga_sync_gen;
  localparam int NI = 4;
  localparam int HD [NI] = '{640, 8, 8, 12};
  localparam int HF [NI] = '{16,  2, 2, 1};
  localparam int HS [NI] = '{96,  3, 3, 4};
  localparam int HB [NI] = '{48,  2, 2, 3};
  localparam int VD [NI] = '{480, 5, 5, 4};
  localparam int VF [NI] = '{10,  1, 1, 2};
  localparam int VS [NI] = '{2,   2, 2, 1};
  localparam int VB [NI] = '{33,  2, 2, 1};
  localparam int DV [NI] = '{4,   1, 4, 16};

  typedef struct {
    int pt;
    int h;
    int v;
    int von;
    int hs;
    int vs;
    int fs;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       pt  [NI];
  logic [9:0] hc  [NI];
  logic [9:0] vc  [NI];
  logic       von [NI];
  logic       hsy [NI];
  logic       vsy [NI];
  logic       fs  [NI];

  int n_chk;
  int n_err;
  int k;
  int cur_i;
  int last_fs [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_sync_gen #(
      .H_DISPLAY(HD[g]), .H_FRONT(HF[g]), .H_SYNC(HS[g]), .H_BACK(HB[g]),
      .V_DISPLAY(VD[g]), .V_FRONT(VF[g]), .V_SYNC(VS[g]), .V_BACK(VB[g]),
      .CLK_DIV(DV[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pixel_tick (pt[g]),
      .Hcount     (hc[g]),
      .Vcount     (vc[g]),
      .video_on   (von[g]),
      .hsync      (hsy[g]),
      .vsync      (vsy[g]),
      .frame_start(fs[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s inst=%0d clk=%0d got=%0d exp=%0d", tag, cur_i, k, got, exp);
    end
  endtask

  // k clk edges since reset release: the pixel index is k/CLK_DIV, folded into the frame.
  function automatic exp_t ref_at(input int i, input int kk);
    exp_t r;
    int ht, vt, n, p;
    ht    = HD[i] + HF[i] + HS[i] + HB[i];
    vt    = VD[i] + VF[i] + VS[i] + VB[i];
    n     = kk / DV[i];
    p     = n % (ht * vt);
    r.h   = p % ht;
    r.v   = p / ht;
    r.pt  = (kk > 0 && (kk % DV[i]) == 0) ? 1 : 0;
    r.fs  = (r.pt == 1 && p == 0) ? 1 : 0;
    r.von = (r.h < HD[i] && r.v < VD[i]) ? 1 : 0;
    r.hs  = (r.h >= HD[i] + HF[i] && r.h < HD[i] + HF[i] + HS[i]) ? 0 : 1;
    r.vs  = (r.v >= VD[i] + VF[i] && r.v < VD[i] + VF[i] + VS[i]) ? 0 : 1;
    return r;
  endfunction

  task automatic check_all();
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      cur_i = i;
      e = ref_at(i, k);
      check_eq("pixel_tick",  int'(pt[i]),  e.pt);
      check_eq("Hcount",      int'(hc[i]),  e.h);
      check_eq("Vcount",      int'(vc[i]),  e.v);
      check_eq("video_on",    int'(von[i]), e.von);
      check_eq("hsync",       int'(hsy[i]), e.hs);
      check_eq("vsync",       int'(vsy[i]), e.vs);
      check_eq("frame_start", int'(fs[i]),  e.fs);
      if (fs[i]) begin
        if (last_fs[i] >= 0)
          check_eq("frame_period", k - last_fs[i],
                   (HD[i] + HF[i] + HS[i] + HB[i]) * (VD[i] + VF[i] + VS[i] + VB[i]) * DV[i]);
        last_fs[i] = k;
      end
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    int hold;
    n_chk = 0;
    n_err = 0;
    k     = 0;
    cur_i = 0;
    for (int i = 0; i < NI; i++) last_fs[i] = -1;
    rst_n = 1'b0;
    repeat ($urandom_range(2, 5)) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    run(12000);
    run($urandom_range(1, 3000));
    // Assert reset between edges; outputs must clear before the next posedge.
    #2;
    rst_n = 1'b0;
    #1;
    k = 0;
    for (int i = 0; i < NI; i++) last_fs[i] = -1;
    check_all();
    hold = $urandom_range(1, 5);
    repeat (hold) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    run(8000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
